i2c_slave_mem: RTL and testbench

// - I2C target (responder) for the I2C master: EEPROM-style byte memory behind a 7-bit device address.
// - Serves byte/page write, current-address read, random read (repeated START) and sequential read.
// - Oversamples SCL/SDA on clk; drives SDA open-drain through sda_o/sda_t; SCL is input only (no stretching).

---
 rtl/i2c_slave_mem.sv | 172 +++++++++++++++++
 tb/tb_i2c_slave_mem.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_mem.sv
// rtl/i2c_slave_mem.sv - I2C target exposing an EEPROM-style byte memory
// SCL/SDA are oversampled on clk; SDA is driven open-drain through sda_t.
module i2c_slave_mem #(
  parameter logic [6:0] DEV_ADDR  = 7'h50,
  parameter int         MEM_DEPTH = 16,
  parameter int         PTR_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_o,
  output logic             sda_t,
  input  logic [PTR_W-1:0] host_addr,
  output logic [7:0]       host_rdata,
  output logic             wr_stb,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic             busy
);

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR_S, DEV_ACK, WORD_ADDR, WORD_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
  } state_t;

  state_t             state_q;
  logic [2:0]         scl_q;
  logic [2:0]         sda_q;
  logic [3:0]         bit_cnt_q;
  logic [7:0]         shift_q;
  logic [PTR_W-1:0]   ptr_q;
  logic               rw_q;
  logic               sda_t_q;
  logic               wr_stb_q;
  logic [PTR_W-1:0]   wr_addr_q;
  logic [7:0]         wr_data_q;
  logic [7:0]         mem_q [MEM_DEPTH];

  logic               scl_s;
  logic               sda_s;
  logic               scl_rise;
  logic               scl_fall;
  logic               start_det;
  logic               stop_det;
  logic               byte_done;
  logic [PTR_W-1:0]   ptr_inc;

  assign scl_s    = scl_q[1];
  assign sda_s    = sda_q[1];
  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  // SCL must be stable high across the SDA edge; a coincident SCL edge is plain data.
  assign start_det = ~sda_q[1] & sda_q[2] & scl_q[1] & scl_q[2];
  assign stop_det  = sda_q[1] & ~sda_q[2] & scl_q[1] & scl_q[2];
  assign byte_done = scl_fall && (bit_cnt_q == 4'd8);
  assign ptr_inc   = (ptr_q == PTR_W'(MEM_DEPTH - 1)) ? '0 : ptr_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q     <= 3'b111;
      sda_q     <= 3'b111;
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      sda_t_q   <= 1'b1;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      scl_q    <= {scl_q[1:0], scl_i};
      sda_q    <= {sda_q[1:0], sda_i};
      wr_stb_q <= 1'b0;
      if (start_det) begin
        state_q   <= DEV_ADDR_S;
        bit_cnt_q <= '0;
        sda_t_q   <= 1'b1;
      end else if (stop_det) begin
        state_q <= IDLE;
        sda_t_q <= 1'b1;
      end else begin
        case (state_q)
          DEV_ADDR_S, WORD_ADDR, WR_DATA: begin
            if (scl_rise) begin
              shift_q   <= {shift_q[6:0], sda_s};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (byte_done) begin
              if (state_q == DEV_ADDR_S) begin
                if (shift_q[7:1] == DEV_ADDR) begin
                  rw_q    <= shift_q[0];
                  sda_t_q <= 1'b0;
                  state_q <= DEV_ACK;
                end else begin
                  state_q <= IDLE;
                end
              end else if (state_q == WORD_ADDR) begin
                ptr_q   <= shift_q[PTR_W-1:0];
                sda_t_q <= 1'b0;
                state_q <= WORD_ACK;
              end else begin
                mem_q[ptr_q] <= shift_q;
                wr_stb_q     <= 1'b1;
                wr_addr_q    <= ptr_q;
                wr_data_q    <= shift_q;
                ptr_q        <= ptr_inc;
                sda_t_q      <= 1'b0;
                state_q      <= WR_ACK;
              end
            end
          end
          DEV_ACK: begin
            if (scl_fall) begin
              bit_cnt_q <= '0;
              if (rw_q) begin
                shift_q <= mem_q[ptr_q];
                sda_t_q <= mem_q[ptr_q][7];
                state_q <= RD_DATA;
              end else begin
                sda_t_q <= 1'b1;
                state_q <= WORD_ADDR;
              end
            end
          end
          WORD_ACK, WR_ACK: begin
            if (scl_fall) begin
              bit_cnt_q <= '0;
              sda_t_q   <= 1'b1;
              state_q   <= WR_DATA;
            end
          end
          RD_DATA: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (byte_done) begin
              sda_t_q <= 1'b1;
              ptr_q   <= ptr_inc;
              state_q <= RD_ACK;
            end else if (scl_fall) begin
              shift_q <= {shift_q[6:0], 1'b0};
              sda_t_q <= shift_q[6];
            end
          end
          RD_ACK: begin
            // NACK ends the read at once; an ACK hands the bus back on the next low phase.
            if (scl_rise && sda_s) begin
              state_q <= IDLE;
            end else if (scl_fall) begin
              bit_cnt_q <= '0;
              shift_q   <= mem_q[ptr_q];
              sda_t_q   <= mem_q[ptr_q][7];
              state_q   <= RD_DATA;
            end
          end
          default: begin
            if (scl_s && !scl_s) state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign sda_o      = 1'b0;
  assign sda_t      = sda_t_q;
  assign wr_stb     = wr_stb_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = (state_q != IDLE);
  assign host_rdata = mem_q[host_addr];

endmodule

// File: tb/tb_i2c_slave_mem.sv
// tb/tb_i2c_slave_mem.sv - directed I2C master driving i2c_slave_mem against a protocol model
module tb_i2c_slave_mem;

  localparam int Q = 5;

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       sda_m;
  logic       sda_bus;
  logic       sda_o;
  logic       sda_t;
  logic [3:0] host_addr;
  logic [7:0] host_rdata;
  logic       wr_stb;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] model_mem [16];
  logic [3:0] model_ptr;
  int         mphase;
  wr_t        exp_q [$];
  logic       mem_chk_en;
  logic       watch_rel;

  assign sda_bus = sda_m & sda_t;

  always #5 clk = ~clk;

  i2c_slave_mem dut (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl),
    .sda_i     (sda_bus),
    .sda_o     (sda_o),
    .sda_t     (sda_t),
    .host_addr (host_addr),
    .host_rdata(host_rdata),
    .wr_stb    (wr_stb),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_q(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    model_ptr = 4'd0;
    mphase    = 0;
    exp_q.delete();
  endtask

  // Protocol model: what the target must answer to each complete byte the master sends.
  task automatic model_byte(input logic [7:0] b, output logic nack);
    nack = 1'b1;
    if (mphase == 1) begin
      if (b[7:1] == 7'h50) begin
        nack   = 1'b0;
        mphase = b[0] ? 4 : 2;
      end else begin
        mphase = 0;
      end
    end else if (mphase == 2) begin
      nack      = 1'b0;
      model_ptr = b[3:0];
      mphase    = 3;
    end else if (mphase == 3) begin
      nack = 1'b0;
      model_mem[model_ptr] = b;
      exp_q.push_back('{a: model_ptr, d: b});
      model_ptr = (model_ptr + 4'd1) % 16;
    end
  endtask

  task automatic clock_bit(input logic b, output logic s);
    wait_q(Q);
    sda_m = b;
    wait_q(Q);
    scl = 1'b1;
    wait_q(Q);
    s = sda_bus;
    wait_q(Q);
    scl = 1'b0;
  endtask

  task automatic i2c_start();
    wait_q(Q);
    sda_m = 1'b1;
    wait_q(Q);
    scl = 1'b1;
    wait_q(Q);
    sda_m = 1'b0;
    wait_q(Q);
    scl = 1'b0;
    mphase = 1;
  endtask

  task automatic i2c_stop();
    wait_q(Q);
    sda_m = 1'b0;
    wait_q(Q);
    scl = 1'b1;
    wait_q(Q);
    sda_m = 1'b1;
    wait_q(Q);
    mphase = 0;
  endtask

  task automatic send_byte(input string name, input logic [7:0] b);
    logic nack_exp;
    logic s;
    model_byte(b, nack_exp);
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, s);
    chk(name, s, nack_exp);
  endtask

  task automatic read_byte(input string name, input logic nack, output logic [7:0] d);
    logic s;
    logic [7:0] exp;
    exp = model_mem[model_ptr];
    model_ptr = (model_ptr + 4'd1) % 16;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, s);
      d = {d[6:0], s};
    end
    chk(name, d, exp);
    clock_bit(nack, s);
    if (nack) mphase = 0;
  endtask

  task automatic peek(input logic [3:0] a, output logic [7:0] d);
    logic found;
    found = 1'b0;
    d = 8'hxx;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (host_addr == a) begin
        found = 1'b1;
        d = host_rdata;
      end
    end
    if (!found) begin
      errors++;
      $display("FAIL peek_timeout: host_addr never reached %0h", a);
    end
  endtask

  task automatic settle_and_sweep();
    wait_q(4);
    mem_chk_en = 1'b1;
    wait_q(20);
  endtask

  initial begin
    host_addr = 4'd0;
    forever begin
      @(posedge clk);
      host_addr = host_addr + 4'd1;
    end
  end

  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (wr_stb) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wr_stb_unexpected: addr %0h data %0h", wr_addr, wr_data);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", wr_addr, e.a);
            chk("wr_data", wr_data, e.d);
          end
        end
        if (mem_chk_en) chk("host_rdata", host_rdata, model_mem[host_addr]);
        if (watch_rel) chk("sda_released", sda_t, 1);
      end
    end
  end

  initial begin
    logic [7:0] d;
    logic s;
    rst = 1'b1;
    scl = 1'b1;
    sda_m = 1'b1;
    mem_chk_en = 1'b0;
    watch_rel = 1'b0;
    model_clear();
    wait_q(4);
    chk("rst_busy", busy, 0);
    chk("rst_sda_t", sda_t, 1);
    chk("rst_wr_stb", wr_stb, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("sda_o_zero", sda_o, 0);
    rst = 1'b0;
    settle_and_sweep();

    mem_chk_en = 1'b0;
    i2c_start();
    wait_q(Q);
    chk("busy_after_start", busy, 1);
    send_byte("bw_dev_ack", 8'hA0);
    send_byte("bw_word_ack", 8'h03);
    send_byte("bw_data_ack", 8'h5A);
    i2c_stop();
    settle_and_sweep();
    chk("bw_wr_addr_lit", wr_addr, 4'd3);
    chk("bw_wr_data_lit", wr_data, 8'h5A);
    peek(4'd3, d);
    chk("bw_mem3_lit", d, 8'h5A);
    chk("bw_all_strobed", exp_q.size(), 0);

    mem_chk_en = 1'b0;
    i2c_start();
    send_byte("pw_dev_ack", 8'hA0);
    send_byte("pw_word_ack", 8'h0E);
    send_byte("pw_d0_ack", 8'h11);
    send_byte("pw_d1_ack", 8'h22);
    send_byte("pw_d2_ack", 8'h33);
    i2c_stop();
    settle_and_sweep();
    peek(4'd14, d);
    chk("pw_mem14_lit", d, 8'h11);
    peek(4'd15, d);
    chk("pw_mem15_lit", d, 8'h22);
    peek(4'd0, d);
    chk("pw_mem0_lit", d, 8'h33);
    chk("pw_wr_addr_lit", wr_addr, 4'd0);
    chk("pw_all_strobed", exp_q.size(), 0);

    mem_chk_en = 1'b0;
    i2c_start();
    send_byte("rr_devw_ack", 8'hA0);
    send_byte("rr_word_ack", 8'h0E);
    i2c_start();
    send_byte("rr_devr_ack", 8'hA1);
    read_byte("rr_byte0", 1'b0, d);
    chk("rr_byte0_lit", d, 8'h11);
    read_byte("rr_byte1", 1'b0, d);
    chk("rr_byte1_lit", d, 8'h22);
    read_byte("rr_byte2", 1'b1, d);
    chk("rr_byte2_lit", d, 8'h33);
    wait_q(Q);
    chk("rr_idle_after_nack", busy, 0);
    i2c_stop();
    settle_and_sweep();

    mem_chk_en = 1'b0;
    watch_rel = 1'b1;
    i2c_start();
    send_byte("mm_dev_nack", 8'hA2);
    chk("mm_busy_low", busy, 0);
    send_byte("mm_data_nack", 8'h00);
    i2c_stop();
    watch_rel = 1'b0;
    settle_and_sweep();

    mem_chk_en = 1'b0;
    i2c_start();
    send_byte("w5_dev_ack", 8'hA0);
    send_byte("w5_word_ack", 8'h05);
    send_byte("w5_data_ack", 8'hC3);
    i2c_stop();
    settle_and_sweep();

    mem_chk_en = 1'b0;
    i2c_start();
    send_byte("ab_dev_ack", 8'hA0);
    send_byte("ab_word_ack", 8'h05);
    clock_bit(1'b1, s);
    clock_bit(1'b0, s);
    clock_bit(1'b1, s);
    clock_bit(1'b0, s);
    i2c_stop();
    wait_q(4);
    chk("ab_idle", busy, 0);
    settle_and_sweep();
    peek(4'd5, d);
    chk("ab_mem5_lit", d, 8'hC3);
    chk("ab_no_pending", exp_q.size(), 0);

    mem_chk_en = 1'b0;
    i2c_start();
    send_byte("rs_devr_ack", 8'hA1);
    d = 8'h00;
    for (int i = 0; i < 4; i++) begin
      clock_bit(1'b1, s);
      d = {d[6:0], s};
    end
    chk("rs_hi_nibble", d[3:0], model_mem[model_ptr][7:4]);
    wait_q(Q);
    chk("rs_bit3_driven_low", sda_t, 0);
    rst = 1'b1;
    model_clear();
    @(negedge clk);
    chk("rs_sda_released", sda_t, 1);
    chk("rs_busy", busy, 0);
    rst = 1'b0;
    i2c_stop();
    settle_and_sweep();
    peek(4'd3, d);
    chk("rs_mem3_cleared_lit", d, 8'h00);
    peek(4'd5, d);
    chk("rs_mem5_cleared_lit", d, 8'h00);
    mem_chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
